// File: rtl/spi_to_axi_stream.sv
// rtl/spi_to_axi_stream.sv - SPI mode-0 slave receiver feeding an 8-bit AXI-Stream through a small FIFO.
module spi_to_axi_stream #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CS,
  output logic [7:0] TDATA,
  output logic       TVALID,
  input  logic       TREADY,
  output logic       TLAST,
  output logic       overflow,
  output logic       frame_err,
  output logic       done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, warm;
  logic sclk_d, cs_d, armed;
  logic sclk_s, mosi_s, cs_s, sclk_rise, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  // A frame can only start once CS has genuinely been sampled high since reset.
  assign cs_fall   = armed & cs_d & ~cs_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      warm      <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (warm[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  logic [0:0] state, state_nx;
  logic [6:0] shift, shift_nx;
  logic [2:0] bit_cnt, cnt_nx, cnt_after;
  logic [7:0] pend_data, pend_data_nx, new_byte;
  logic       pend_full, pend_full_nx, flush, flush_nx;
  logic       push, completing, ferr_nx, ovf_clr;
  logic [8:0] push_word;

  assign new_byte  = {shift, mosi_s};
  assign cnt_after = sclk_rise ? bit_cnt + 3'd1 : bit_cnt;

  always_comb begin
    state_nx     = state;
    shift_nx     = shift;
    cnt_nx       = bit_cnt;
    pend_data_nx = pend_data;
    pend_full_nx = pend_full;
    flush_nx     = flush;
    push         = 1'b0;
    push_word    = {1'b0, pend_data};
    completing   = 1'b0;
    ferr_nx      = 1'b0;
    ovf_clr      = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          push         = 1'b1;
          push_word    = {1'b1, pend_data};
          pend_full_nx = 1'b0;
          flush_nx     = 1'b0;
        end
        if (cs_fall) begin
          state_nx = RECV;
          cnt_nx   = 3'd0;
          ovf_clr  = 1'b1;
        end
      end
      RECV: begin
        if (sclk_rise) begin
          shift_nx = new_byte[6:0];
          cnt_nx   = cnt_after;
          if (bit_cnt == 3'd7) begin
            completing   = 1'b1;
            pend_data_nx = new_byte;
            pend_full_nx = 1'b1;
            if (pend_full) push = 1'b1;
          end
        end
        if (cs_rise) begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
          ferr_nx  = (cnt_after != 3'd0);
          // The port may already be busy with the previous byte; emit the final one next cycle.
          if (completing) begin
            flush_nx = 1'b1;
          end else if (pend_full) begin
            push         = 1'b1;
            push_word    = {1'b1, pend_data};
            pend_full_nx = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, wr_ok;

  assign TVALID = (wr_ptr != rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = TVALID & TREADY;
  assign wr_ok  = push & (~full | pop);
  assign TDATA  = mem[rd_ptr[AW-1:0]][7:0];
  assign TLAST  = mem[rd_ptr[AW-1:0]][8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      pend_data <= '0;
      pend_full <= 1'b0;
      flush     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      bit_cnt   <= cnt_nx;
      pend_data <= pend_data_nx;
      pend_full <= pend_full_nx;
      flush     <= flush_nx;
      frame_err <= ferr_nx;
      done      <= pop & TLAST;
      if (wr_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_word;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_ok) overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_to_axi_stream.sv
// tb/tb_spi_to_axi_stream.sv - self-checking bench for spi_to_axi_stream.
module tb_spi_to_axi_stream;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       SCLK = 1'b0, MOSI = 1'b0, CS = 1'b1, TREADY;
  logic [7:0] TDATA;
  logic       TVALID, TLAST, overflow, frame_err, done;

  spi_to_axi_stream #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
    .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST),
    .overflow(overflow), .frame_err(frame_err), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, ferr_cnt = 0, stab_err = 0;
  logic [8:0] got_q[$], exp_q[$];
  logic [7:0] tx_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;

  // 0: hold ready_hold, 1: toggle every clk, 2: random
  int   ready_mode = 0;
  logic ready_hold = 1'b1;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1)      TREADY = ~TREADY;
    else if (ready_mode == 2) TREADY = 1'($urandom_range(0, 1));
    else                      TREADY = ready_hold;
  end
  initial TREADY = 1'b1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall && (!TVALID || {TLAST, TDATA} !== prev_word)) stab_err <= stab_err + 1;
      if (TVALID && TREADY) got_q.push_back({TLAST, TDATA});
      if (done)      done_cnt <= done_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      prev_stall <= TVALID && !TREADY;
      prev_word  <= {TLAST, TDATA};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    MOSI = b;
    #30 SCLK = 1'b1;
    #30 SCLK = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) spi_bit(v[i]);
  endtask

  task automatic send_frame(input int extra, input logic [7:0] pat);
    CS = 1'b0;
    #40;
    foreach (tx_q[i]) send_bits(tx_q[i], 8);
    if (extra > 0) send_bits(pat, extra);
    #30 CS = 1'b1;
    #80;
  endtask

  // Reference: each frame byte becomes a beat, last flags the final byte; a stalled
  // sink keeps only the first 'cap' bytes of the frame.
  task automatic model_frame(input int cap);
    for (int i = 0; i < tx_q.size(); i++)
      if (i < cap) exp_q.push_back({1'(i == tx_q.size() - 1), tx_q[i]});
  endtask

  task automatic wait_and_compare(input string name);
    int n;
    n = exp_q.size();
    for (int k = 0; k < 400 && got_q.size() < n; k++) @(posedge clk);
    repeat (10) @(posedge clk);
    check({name, "_count"}, got_q.size(), n);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, "_beat"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  typedef struct {
    int              n;
    logic [3:0][7:0] b;
    int              extra;
    logic [7:0]      pat;
    int              exp_ferr;
  } vec_t;
  vec_t tbl[3];

  int f0, d0, exp_ferr;

  initial begin
    tbl[0].n = 1; tbl[0].b = {8'h00, 8'h00, 8'h00, 8'hA5}; tbl[0].extra = 0; tbl[0].pat = 8'h00; tbl[0].exp_ferr = 0;
    tbl[1].n = 3; tbl[1].b = {8'h00, 8'h03, 8'h02, 8'h01}; tbl[1].extra = 0; tbl[1].pat = 8'h00; tbl[1].exp_ferr = 0;
    tbl[2].n = 1; tbl[2].b = {8'h00, 8'h00, 8'h00, 8'h3C}; tbl[2].extra = 4; tbl[2].pat = 8'hA0; tbl[2].exp_ferr = 1;

    #23;
    check("reset_outputs", {TVALID, TLAST, TDATA, overflow, frame_err, done}, 0);
    reset_n = 1'b1;
    #107;

    foreach (tbl[v]) begin
      tx_q.delete();
      for (int i = 0; i < tbl[v].n; i++) tx_q.push_back(tbl[v].b[i]);
      f0 = ferr_cnt; d0 = done_cnt;
      model_frame(1000);
      send_frame(tbl[v].extra, tbl[v].pat);
      wait_and_compare($sformatf("table%0d", v));
      check($sformatf("table%0d_frame_err", v), ferr_cnt - f0, tbl[v].exp_ferr);
      check($sformatf("table%0d_done", v), done_cnt - d0, 1);
    end

    // Overflow with a stalled sink, then drain.
    ready_hold = 1'b0;
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    d0 = done_cnt;
    model_frame(4);
    send_frame(0, 8'h00);
    repeat (10) @(posedge clk);
    check("ovf_flag", overflow, 1);
    check("ovf_held_valid", TVALID, 1);
    check("ovf_no_beats", got_q.size(), 0);
    ready_hold = 1'b1;
    wait_and_compare("ovf_drain");
    check("ovf_done", done_cnt - d0, 0);
    check("ovf_sticky", overflow, 1);
    tx_q = '{8'h5A};
    model_frame(1000);
    send_frame(0, 8'h00);
    check("ovf_cleared", overflow, 0);
    wait_and_compare("after_ovf");

    // Reset mid-frame, CS still low at release.
    CS = 1'b0;
    #40;
    send_bits(8'hF8, 5);
    #3 reset_n = 1'b0;
    #20;
    check("midreset_outputs", {TVALID, TLAST, TDATA, overflow, frame_err, done}, 0);
    #30 reset_n = 1'b1;
    #97;
    send_bits(8'hFF, 8);
    #50;
    check("cs_low_ignored", got_q.size() + 32'(TVALID), 0);
    CS = 1'b1;
    #80;
    tx_q = '{8'h81};
    model_frame(1000);
    send_frame(0, 8'h00);
    wait_and_compare("post_reset");

    // Back-to-back frames with a toggling sink.
    ready_mode = 1;
    d0 = done_cnt;
    tx_q = '{8'h11, 8'h22};
    model_frame(1000);
    send_frame(0, 8'h00);
    tx_q = '{8'h33};
    model_frame(1000);
    send_frame(0, 8'h00);
    wait_and_compare("toggle");
    check("toggle_done", done_cnt - d0, 2);

    // Randomised frames against the reference model.
    ready_mode = 2;
    for (int r = 0; r < 12; r++) begin
      int n, extra;
      tx_q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      exp_ferr = (extra != 0) ? 1 : 0;
      f0 = ferr_cnt; d0 = done_cnt;
      model_frame(1000);
      send_frame(extra, 8'($urandom));
      wait_and_compare($sformatf("rand%0d", r));
      check($sformatf("rand%0d_frame_err", r), ferr_cnt - f0, exp_ferr);
      check($sformatf("rand%0d_done", r), done_cnt - d0, 1);
    end

    check("stall_stability", stab_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
